// File: rtl/rtc_time_edit.sv
// HH:MM:SS display latch with key-driven time set, blink and RTC write handshake.
// Feeds the six-digit BCD seven-segment driver and the DS1302 writer.
module rtc_time_edit #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rtc_valid,
  input  logic [23:0] rtc_time,
  input  logic        key_mode,
  input  logic        key_up,
  output logic        wr_req,
  output logic [23:0] wr_time,
  input  logic        wr_ack,
  output logic [23:0] seg_bcd,
  output logic [7:0]  seg_en
);

  localparam int CW = $clog2(BLINK_HALF);

  typedef enum logic [2:0] {
    RUN, SET_HH, SET_MM, SET_SS, COMMIT
  } state_t;

  state_t        state, state_n;
  logic [23:0]   disp, disp_n;
  logic [23:0]   edit, edit_n;
  logic [23:0]   wr_time_n;
  logic          wr_req_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          blank, blank_n;
  logic          clr;
  logic          in_set_n;

  // Invalid BCD or the field maximum wraps to 00.
  function automatic logic [7:0] inc_field(
    input logic [7:0] f,
    input logic [3:0] tmax,
    input logic [7:0] fmax
  );
    logic [7:0] r;
    if (f[3:0] > 4'd9 || f[7:4] > tmax || f == fmax)
      r = 8'h00;
    else if (f[3:0] == 4'd9)
      r = {f[7:4] + 4'd1, 4'h0};
    else
      r = {f[7:4], f[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    state_n   = state;
    disp_n    = disp;
    edit_n    = edit;
    wr_req_n  = wr_req;
    wr_time_n = wr_time;
    clr       = 1'b0;
    unique case (state)
      RUN: begin
        if (key_mode) begin
          edit_n  = disp;
          state_n = SET_HH;
          clr     = 1'b1;
        end else if (rtc_valid) begin
          disp_n = rtc_time;
        end
      end
      SET_HH: begin
        if (key_mode) begin
          state_n = SET_MM;
          clr     = 1'b1;
        end else if (key_up) begin
          edit_n[23:16] = inc_field(edit[23:16], 4'd2, 8'h23);
          clr           = 1'b1;
        end
      end
      SET_MM: begin
        if (key_mode) begin
          state_n = SET_SS;
          clr     = 1'b1;
        end else if (key_up) begin
          edit_n[15:8] = inc_field(edit[15:8], 4'd5, 8'h59);
          clr          = 1'b1;
        end
      end
      SET_SS: begin
        if (key_mode) begin
          state_n   = COMMIT;
          wr_req_n  = 1'b1;
          wr_time_n = edit;
        end else if (key_up) begin
          edit_n[7:0] = inc_field(edit[7:0], 4'd5, 8'h59);
          clr         = 1'b1;
        end
      end
      COMMIT: begin
        if (wr_ack) begin
          wr_req_n = 1'b0;
          disp_n   = edit;
          state_n  = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign in_set_n = (state_n == SET_HH) || (state_n == SET_MM) ||
                    (state_n == SET_SS);

  always_comb begin
    cnt_n   = cnt;
    blank_n = blank;
    if (!in_set_n || clr) begin
      cnt_n   = '0;
      blank_n = 1'b0;
    end else if (cnt == CW'(BLINK_HALF - 1)) begin
      cnt_n   = '0;
      blank_n = ~blank;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      disp    <= '0;
      edit    <= '0;
      wr_req  <= 1'b0;
      wr_time <= '0;
      cnt     <= '0;
      blank   <= 1'b0;
      seg_bcd <= '0;
      seg_en  <= 8'h00;
    end else begin
      state   <= state_n;
      disp    <= disp_n;
      edit    <= edit_n;
      wr_req  <= wr_req_n;
      wr_time <= wr_time_n;
      cnt     <= cnt_n;
      blank   <= blank_n;
      seg_bcd <= (state_n == RUN) ? disp_n : edit_n;
      seg_en  <= blank_n ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_rtc_time_edit.sv
// Directed bench for rtc_time_edit: vector table plus edit, blink
// and handshake sequences.
module tb_rtc_time_edit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rtc_valid = 1'b0;
  logic [23:0] rtc_time = '0;
  logic        key_mode = 1'b0;
  logic        key_up = 1'b0;
  logic        wr_req;
  logic [23:0] wr_time;
  logic        wr_ack = 1'b0;
  logic [23:0] seg_bcd;
  logic [7:0]  seg_en;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rtc_time_edit #(.BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst),
    .rtc_valid(rtc_valid), .rtc_time(rtc_time),
    .key_mode(key_mode), .key_up(key_up),
    .wr_req(wr_req), .wr_time(wr_time), .wr_ack(wr_ack),
    .seg_bcd(seg_bcd), .seg_en(seg_en)
  );

  typedef struct {
    logic        v;
    logic [23:0] t;
    logic        m;
    logic        u;
    logic        a;
    logic        cs;
    logic        cw;
    logic [23:0] seg;
    logic [7:0]  en;
    logic        req;
    logic [23:0] wt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // One clock with the given inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [23:0] t,
                     input logic m, input logic u, input logic a);
    rtc_valid = v; rtc_time = t;
    key_mode = m; key_up = u; wr_ack = a;
    @(posedge clk);
    #1;
    rtc_valid = 1'b0; key_mode = 1'b0;
    key_up = 1'b0; wr_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 24'h235958, 0, 0, 0, 1, 1, 24'h235958, 8'h00, 0, 24'h0};
    tbl[1]  = '{0, 24'h0, 1, 0, 0, 1, 1, 24'h235958, 8'h00, 0, 24'h0};
    tbl[2]  = '{0, 24'h0, 0, 1, 0, 1, 1, 24'h005958, 8'h00, 0, 24'h0};
    tbl[3]  = '{0, 24'h0, 1, 0, 0, 1, 1, 24'h005958, 8'h00, 0, 24'h0};
    tbl[4]  = '{0, 24'h0, 0, 1, 0, 1, 1, 24'h000058, 8'h00, 0, 24'h0};
    tbl[5]  = '{0, 24'h0, 1, 0, 0, 1, 1, 24'h000058, 8'h00, 0, 24'h0};
    tbl[6]  = '{0, 24'h0, 0, 1, 0, 1, 1, 24'h000059, 8'h00, 0, 24'h0};
    tbl[7]  = '{0, 24'h0, 1, 0, 0, 0, 1, 24'h0, 8'h00, 1, 24'h000059};
    for (int i = 8; i < 13; i++)
      tbl[i] = '{0, 24'h0, 0, 0, 0, 0, 1, 24'h0, 8'h00, 1, 24'h000059};
    tbl[13] = '{0, 24'h0, 0, 0, 1, 1, 0, 24'h000059, 8'h00, 0, 24'h0};
    tbl[14] = '{1, 24'h121212, 0, 0, 0, 1, 0, 24'h121212, 8'h00, 0, 24'h0};
    tbl[15] = '{0, 24'h0, 0, 1, 0, 1, 0, 24'h121212, 8'h00, 0, 24'h0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_seg", 0, 32'(seg_bcd), 32'h0);
    chk("rst_en", 0, 32'(seg_en), 32'h0);
    chk("rst_req", 0, 32'(wr_req), 32'h0);
    chk("rst_wt", 0, 32'(wr_time), 32'h0);

    // Main edit/commit path from 23:59:58
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].t, tbl[i].m, tbl[i].u, tbl[i].a);
      if (tbl[i].cs) chk("tbl_seg", i, 32'(seg_bcd), 32'(tbl[i].seg));
      if (tbl[i].cw) chk("tbl_wt", i, 32'(wr_time), 32'(tbl[i].wt));
      chk("tbl_en", i, 32'(seg_en), 32'(tbl[i].en));
      chk("tbl_req", i, 32'(wr_req), 32'(tbl[i].req));
    end

    // Hour stepping 19 -> 20 .. 23 -> 00
    do_reset();
    cyc(1, 24'h195900, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    begin
      logic [7:0] hrs[5];
      hrs = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h00};
      for (int i = 0; i < 5; i++) begin
        cyc(0, 0, 0, 1, 0);
        chk("hour_step", i, 32'(seg_bcd), 32'({hrs[i], 16'h5900}));
      end
    end

    // Invalid minute, rtc_valid ignored, simultaneous keys
    do_reset();
    cyc(1, 24'h129A34, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("min_invalid", 0, 32'(seg_bcd), 32'h120034);
    cyc(1, 24'h121212, 0, 0, 0);
    chk("set_ignores_rtc", 0, 32'(seg_bcd), 32'h120034);
    cyc(0, 0, 1, 1, 0);
    chk("mode_beats_up", 0, 32'(seg_bcd), 32'h120034);
    cyc(0, 0, 0, 1, 0);
    chk("now_in_ss", 0, 32'(seg_bcd), 32'h120035);

    // Blink with BLINK_HALF=4, then restart by key_up during blank
    do_reset();
    cyc(0, 0, 1, 0, 0);
    chk("blink", 0, 32'(seg_en), 32'h00);
    for (int i = 1; i < 13; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("blink", i, 32'(seg_en),
          (i >= 4 && i < 8) || i == 12 ? 32'hFF : 32'h00);
    end
    cyc(0, 0, 0, 1, 0);
    chk("blink_restart", 0, 32'(seg_en), 32'h00);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("blink_restart", i, 32'(seg_en), i == 4 ? 32'hFF : 32'h00);
    end

    // Ack already high on first COMMIT cycle
    do_reset();
    cyc(1, 24'h010203, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk("early_ack_req1", 0, 32'(wr_req), 32'h1);
    chk("early_ack_wt", 0, 32'(wr_time), 32'h010203);
    cyc(0, 0, 0, 0, 1);
    chk("early_ack_req0", 0, 32'(wr_req), 32'h0);
    chk("early_ack_seg", 0, 32'(seg_bcd), 32'h010203);

    // Reset while COMMIT is pending
    cyc(1, 24'h040506, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("commit_req", 0, 32'(wr_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_commit_req", 0, 32'(wr_req), 32'h0);
    chk("rst_commit_seg", 0, 32'(seg_bcd), 32'h0);
    chk("rst_commit_wt", 0, 32'(wr_time), 32'h0);
    chk("rst_commit_en", 0, 32'(seg_en), 32'h0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("no_req_after_rst", i, 32'(wr_req), 32'h0);
    end
    cyc(1, 24'h111111, 0, 0, 0);
    chk("run_after_rst", 0, 32'(seg_bcd), 32'h111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
